// File: rtl/banco_pkg.sv
// Shared defaults for the general-purpose register bank.
package banco_pkg;

  localparam int BANCO_DATA_W = 32;
  localparam int BANCO_ADDR_W = 5;
  localparam int BANCO_NUM_RD = 2;
  localparam int BANCO_DEPTH  = 2 ** BANCO_ADDR_W;

  function automatic int banco_depth(input int addr_w);
    return 2 ** addr_w;
  endfunction

endpackage

// File: rtl/banco_puerto_lectura.sv
// One combinational read lane: array mux, writeback bypass, zero-register override.
module banco_puerto_lectura
  import banco_pkg::*;
#(
  parameter int DATA_W   = BANCO_DATA_W,
  parameter int ADDR_W   = BANCO_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic [banco_depth(ADDR_W)-1:0][DATA_W-1:0] mem_i,
  input  logic [banco_depth(ADDR_W)-1:0]             busy_i,
  input  logic [ADDR_W-1:0]                          ra_i,
  input  logic [ADDR_W-1:0]                          wa_i,
  input  logic [DATA_W-1:0]                          dw_i,
  input  logic                                       we_i,
  input  logic                                       rst_i,
  output logic [DATA_W-1:0]                          dr_o,
  output logic                                       busy_o
);

  always_comb begin
    dr_o   = mem_i[ra_i];
    busy_o = busy_i[ra_i];
    if ((ZERO_REG != 0) && (ra_i == '0)) begin
      dr_o   = '0;
      busy_o = 1'b0;
    end else if (we_i && !rst_i && (wa_i == ra_i)) begin
      // Writeback in flight: the reader sees the new value and a free register.
      dr_o   = dw_i;
      busy_o = 1'b0;
    end
  end

endmodule

// File: rtl/banco_registros_param.sv
// Parametrised register bank with write bypass, optional zero register and busy scoreboard.
module banco_registros_param
  import banco_pkg::*;
#(
  parameter int DATA_W   = BANCO_DATA_W,
  parameter int ADDR_W   = BANCO_ADDR_W,
  parameter int NUM_RD   = BANCO_NUM_RD,
  parameter int ZERO_REG = 1
) (
  input  logic                     CLK_BANCO,
  input  logic                     RST_BANCO,
  input  logic [NUM_RD*ADDR_W-1:0] RA_BANCO,
  output logic [NUM_RD*DATA_W-1:0] DR_BANCO,
  output logic [NUM_RD-1:0]        BUSY_BANCO,
  input  logic [ADDR_W-1:0]        WA_BANCO,
  input  logic [DATA_W-1:0]        DW_BANCO,
  input  logic                     WE_BANCO,
  input  logic                     RES_BANCO,
  input  logic [ADDR_W-1:0]        RES_ADDR_BANCO
);

  localparam int DEPTH = banco_depth(ADDR_W);

  logic [DEPTH-1:0][DATA_W-1:0] mem_q, mem_d;
  logic [DEPTH-1:0]             busy_q, busy_d;

  logic wr_ok, res_ok;

  assign wr_ok  = WE_BANCO  && !((ZERO_REG != 0) && (WA_BANCO == '0));
  assign res_ok = RES_BANCO && !((ZERO_REG != 0) && (RES_ADDR_BANCO == '0));

  always_comb begin
    mem_d  = mem_q;
    busy_d = busy_q;
    if (wr_ok) begin
      mem_d[WA_BANCO]  = DW_BANCO;
      busy_d[WA_BANCO] = 1'b0;
    end
    // Applied after the write so a new producer on the same register keeps it busy.
    if (res_ok) begin
      busy_d[RES_ADDR_BANCO] = 1'b1;
    end
  end

  always_ff @(posedge CLK_BANCO) begin
    if (RST_BANCO) begin
      mem_q  <= '0;
      busy_q <= '0;
    end else begin
      mem_q  <= mem_d;
      busy_q <= busy_d;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    banco_puerto_lectura #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .ZERO_REG(ZERO_REG)
    ) u_rd (
      .mem_i (mem_q),
      .busy_i(busy_q),
      .ra_i  (RA_BANCO[i*ADDR_W +: ADDR_W]),
      .wa_i  (WA_BANCO),
      .dw_i  (DW_BANCO),
      .we_i  (WE_BANCO),
      .rst_i (RST_BANCO),
      .dr_o  (DR_BANCO[i*DATA_W +: DATA_W]),
      .busy_o(BUSY_BANCO[i])
    );
  end

endmodule

// File: tb/tb_banco_registros_param.sv
// Bench for banco_registros_param: default 32x32/2-port bank and a 16x8/4-port bank.
module tb_banco_registros_param;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Instance A: DATA_W=32, ADDR_W=5, NUM_RD=2, ZERO_REG=1
  logic        rst_a, we_a, res_a;
  logic [9:0]  ra_a;
  logic [63:0] dr_a;
  logic [1:0]  busy_a;
  logic [4:0]  wa_a, resaddr_a;
  logic [31:0] dw_a;

  banco_registros_param #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1)) dut_a (
    .CLK_BANCO(clk), .RST_BANCO(rst_a), .RA_BANCO(ra_a), .DR_BANCO(dr_a),
    .BUSY_BANCO(busy_a), .WA_BANCO(wa_a), .DW_BANCO(dw_a), .WE_BANCO(we_a),
    .RES_BANCO(res_a), .RES_ADDR_BANCO(resaddr_a));

  // Instance B: DATA_W=16, ADDR_W=3, NUM_RD=4, ZERO_REG=1
  logic        rst_b, we_b, res_b;
  logic [11:0] ra_b;
  logic [63:0] dr_b;
  logic [3:0]  busy_b;
  logic [2:0]  wa_b, resaddr_b;
  logic [15:0] dw_b;

  banco_registros_param #(.DATA_W(16), .ADDR_W(3), .NUM_RD(4), .ZERO_REG(1)) dut_b (
    .CLK_BANCO(clk), .RST_BANCO(rst_b), .RA_BANCO(ra_b), .DR_BANCO(dr_b),
    .BUSY_BANCO(busy_b), .WA_BANCO(wa_b), .DW_BANCO(dw_b), .WE_BANCO(we_b),
    .RES_BANCO(res_b), .RES_ADDR_BANCO(resaddr_b));

  // Reference state: plain arrays of register contents and pending-producer flags.
  logic [31:0] ma [32];
  logic        pa [32];
  logic [15:0] mb [8];
  logic        pb [8];

  always @(posedge clk) begin
    if (rst_a) begin
      for (int i = 0; i < 32; i++) begin ma[i] <= '0; pa[i] <= 1'b0; end
    end else begin
      if (we_a && wa_a != 0) begin ma[wa_a] <= dw_a; pa[wa_a] <= 1'b0; end
      if (res_a && resaddr_a != 0) pa[resaddr_a] <= 1'b1;
    end
    if (rst_b) begin
      for (int i = 0; i < 8; i++) begin mb[i] <= '0; pb[i] <= 1'b0; end
    end else begin
      if (we_b && wa_b != 0) begin mb[wa_b] <= dw_b; pb[wa_b] <= 1'b0; end
      if (res_b && resaddr_b != 0) pb[resaddr_b] <= 1'b1;
    end
  end

  function automatic logic [31:0] exp_dr_a(input int p);
    logic [4:0] r = ra_a[p*5 +: 5];
    if (r == 0) return '0;
    if (we_a && !rst_a && wa_a == r) return dw_a;
    return ma[r];
  endfunction

  function automatic logic exp_busy_a(input int p);
    logic [4:0] r = ra_a[p*5 +: 5];
    if (r == 0) return 1'b0;
    if (we_a && !rst_a && wa_a == r) return 1'b0;
    return pa[r];
  endfunction

  function automatic logic [15:0] exp_dr_b(input int p);
    logic [2:0] r = ra_b[p*3 +: 3];
    if (r == 0) return '0;
    if (we_b && !rst_b && wa_b == r) return dw_b;
    return mb[r];
  endfunction

  function automatic logic exp_busy_b(input int p);
    logic [2:0] r = ra_b[p*3 +: 3];
    if (r == 0) return 1'b0;
    if (we_b && !rst_b && wa_b == r) return 1'b0;
    return pb[r];
  endfunction

  task automatic chk(input string nm, input int lane, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s lane %0d: got 0x%0h, expected 0x%0h (t=%0t)", nm, lane, act, exp, $time);
    end
  endtask

  // Literal expectation checked against both the DUT and the reference model.
  task automatic lit(input string nm, input int lane, input logic [63:0] dut_v,
                     input logic [63:0] mdl_v, input logic [63:0] exp);
    chk({nm, "_dut"}, lane, dut_v, exp);
    chk({nm, "_model"}, lane, mdl_v, exp);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int p = 0; p < 2; p++) begin
        chk("a_dr", p, 64'(dr_a[p*32 +: 32]), 64'(exp_dr_a(p)));
        chk("a_busy", p, 64'(busy_a[p]), 64'(exp_busy_a(p)));
      end
      for (int p = 0; p < 4; p++) begin
        chk("b_dr", p, 64'(dr_b[p*16 +: 16]), 64'(exp_dr_b(p)));
        chk("b_busy", p, 64'(busy_b[p]), 64'(exp_busy_b(p)));
      end
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    we_a = 1'b0; res_a = 1'b0;
  endtask

  initial begin
    rst_a = 1'b1; we_a = 1'b0; res_a = 1'b0; ra_a = '0; wa_a = '0; dw_a = '0; resaddr_a = '0;
    rst_b = 1'b1; we_b = 1'b0; res_b = 1'b0; ra_b = '0; wa_b = '0; dw_b = '0; resaddr_b = '0;
    next();
    chk_en = 1'b1;
    #3;
    lit("rst_init_dr", 0, 64'(dr_a[31:0]), 64'(exp_dr_a(0)), 64'h0);
    lit("rst_init_busy", 1, 64'(busy_a[1]), 64'(exp_busy_a(1)), 64'h0);
    rst_a = 1'b0; rst_b = 1'b0;
    next();

    // Random traffic, then a two-cycle reset with a write that must be ignored.
    for (int k = 0; k < 6; k++) begin
      we_a = 1'b1; wa_a = 5'($urandom_range(1, 15)); dw_a = $urandom;
      res_a = 1'b1; resaddr_a = 5'($urandom_range(1, 15));
      ra_a = {5'($urandom_range(1, 15)), wa_a};
      next();
    end
    rst_a = 1'b1; we_a = 1'b1; wa_a = 5'd3; dw_a = 32'hDEAD_BEEF; res_a = 1'b0; ra_a = {5'd3, 5'd3};
    next();
    we_a = 1'b0;
    next();
    rst_a = 1'b0; ra_a = {5'd4, 5'd3};
    #3;
    lit("rst_reg3", 0, 64'(dr_a[31:0]), 64'(exp_dr_a(0)), 64'h0);
    lit("rst_busy", 0, 64'(busy_a[0]), 64'(exp_busy_a(0)), 64'h0);
    next();

    // Write reg 5: bypass on port 1 in the write cycle, array read next cycle.
    we_a = 1'b1; wa_a = 5'd5; dw_a = 32'h1234_5678; ra_a = {5'd5, 5'd1};
    #3;
    lit("bypass", 1, 64'(dr_a[63:32]), 64'(exp_dr_a(1)), 64'h1234_5678);
    next();
    idle_a(); ra_a = {5'd1, 5'd5};
    #3;
    lit("wr_read", 0, 64'(dr_a[31:0]), 64'(exp_dr_a(0)), 64'h1234_5678);
    next();

    // Register 0: write and reserve both dropped.
    we_a = 1'b1; wa_a = 5'd0; dw_a = 32'hFFFF_FFFF; res_a = 1'b1; resaddr_a = 5'd0; ra_a = {5'd0, 5'd0};
    next();
    idle_a();
    for (int k = 0; k < 3; k++) begin
      #3;
      lit("zero_dr", 0, 64'(dr_a[31:0]), 64'(exp_dr_a(0)), 64'h0);
      lit("zero_busy", 0, 64'(busy_a[0]), 64'(exp_busy_a(0)), 64'h0);
      next();
    end

    // Scoreboard on reg 7.
    res_a = 1'b1; resaddr_a = 5'd7; ra_a = {5'd7, 5'd7};
    #3;
    lit("res_same_cycle", 0, 64'(busy_a[0]), 64'(exp_busy_a(0)), 64'h0);
    next();
    idle_a();
    for (int k = 0; k < 3; k++) begin
      #3;
      lit("res_held", 0, 64'(busy_a[0]), 64'(exp_busy_a(0)), 64'h1);
      next();
    end
    we_a = 1'b1; wa_a = 5'd7; dw_a = 32'hA5;
    #3;
    lit("wb_busy", 0, 64'(busy_a[0]), 64'(exp_busy_a(0)), 64'h0);
    lit("wb_dr", 1, 64'(dr_a[63:32]), 64'(exp_dr_a(1)), 64'hA5);
    next();
    idle_a();
    #3;
    lit("post_wb_busy", 0, 64'(busy_a[0]), 64'(exp_busy_a(0)), 64'h0);
    lit("post_wb_dr", 0, 64'(dr_a[31:0]), 64'(exp_dr_a(0)), 64'hA5);
    next();

    // Write and reserve reg 9 on the same edge: reservation wins.
    we_a = 1'b1; wa_a = 5'd9; dw_a = 32'h55; res_a = 1'b1; resaddr_a = 5'd9;
    next();
    idle_a(); ra_a = {5'd9, 5'd9};
    #3;
    lit("wr_res_dr", 0, 64'(dr_a[31:0]), 64'(exp_dr_a(0)), 64'h55);
    lit("wr_res_busy", 1, 64'(busy_a[1]), 64'(exp_busy_a(1)), 64'h1);
    next();

    // Instance B: fill regs 1..4, read all four lanes at once.
    for (int k = 1; k <= 4; k++) begin
      we_b = 1'b1; wa_b = 3'(k); dw_b = 16'(k * 16'h1111);
      next();
    end
    we_b = 1'b0; ra_b = {3'd4, 3'd3, 3'd2, 3'd1};
    #3;
    chk("pack_dut", 0, dr_b, 64'h4444_3333_2222_1111);
    chk("pack_model", 0, {exp_dr_b(3), exp_dr_b(2), exp_dr_b(1), exp_dr_b(0)}, 64'h4444_3333_2222_1111);
    next();
    res_b = 1'b1; resaddr_b = 3'd2;
    next();
    res_b = 1'b0;
    #3;
    lit("b_reserved", 1, 64'(busy_b[1]), 64'(exp_busy_b(1)), 64'h1);
    next();
    rst_b = 1'b1;
    next();
    rst_b = 1'b0;
    #3;
    lit("b_rst_busy", 0, 64'(busy_b), 64'({exp_busy_b(3), exp_busy_b(2), exp_busy_b(1), exp_busy_b(0)}), 64'h0);
    lit("b_rst_dr", 0, dr_b, {exp_dr_b(3), exp_dr_b(2), exp_dr_b(1), exp_dr_b(0)}, 64'h0);
    next();
    next();

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
